// File: rtl/lc3_alu_sequencer.sv
// LC-3 operate-datapath sequencer: fetch, decode, ALU exec, BR, HALT.
// Optional retire counter enabled by defining LC3_SEQ_PERF_CNT_EN.
module lc3_alu_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h3000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic [2:0]  sr1,
  output logic [2:0]  sr2,
  output logic [2:0]  dr,
  output logic [4:0]  IR,
  output logic        IR_5,
  output logic [1:0]  ALUctrl,
  input  logic [15:0] alu_out,
  output logic        reg_we,
  output logic [2:0]  nzp,
  output logic        halted,
  output logic        illegal
`ifdef LC3_SEQ_PERF_CNT_EN
  ,
  output logic [15:0] retired_cnt
`endif
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_AND  = 2'b01;
  localparam logic [1:0] ALU_NOT  = 2'b10;
  localparam logic [1:0] ALU_PASS = 2'b11;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [2:0]  nzp_q, nzp_d;
  logic        ill_q, ill_d;
  logic [1:0]  alu_q, alu_d;
  logic        ir5_q, ir5_d;
  logic        we_q, we_d;

  logic        is_alu;
  logic        is_br;
  logic        is_halt;
  logic        br_take;
  logic [15:0] br_off;

  // Decode of the latched instruction word, used in DECODE
  always_comb begin
    is_alu  = (instr_q[15:12] == OP_ADD) ||
              (instr_q[15:12] == OP_AND) ||
              (instr_q[15:12] == OP_NOT);
    is_br   = (instr_q[15:12] == OP_BR);
    is_halt = (instr_q[15:12] == OP_TRAP) &&
              (instr_q[7:0] == 8'h25);
    br_take = |(instr_q[11:9] & nzp_q);
    br_off  = {{7{instr_q[8]}}, instr_q[8:0]};
  end

  // Next-state and next-control computation for the whole FSM
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    nzp_d   = nzp_q;
    ill_d   = ill_q;
    alu_d   = ALU_PASS;
    ir5_d   = 1'b0;
    we_d    = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          instr_d = mem_rdata;
          pc_d    = pc_q + 16'd1;
          state_d = S_DECODE;
          // Controls are set up one edge early so DECODE sees them registered
          unique case (mem_rdata[15:12])
            OP_ADD: begin
              alu_d = ALU_ADD;
              ir5_d = mem_rdata[5];
            end
            OP_AND: begin
              alu_d = ALU_AND;
              ir5_d = mem_rdata[5];
            end
            OP_NOT:  alu_d = ALU_NOT;
            default: alu_d = ALU_PASS;
          endcase
        end
      end
      S_DECODE: begin
        state_d = S_FETCH;
        unique case (1'b1)
          is_alu: begin
            alu_d   = alu_q;
            ir5_d   = ir5_q;
            we_d    = 1'b1;
            state_d = S_EXEC;
          end
          is_br: begin
            if (br_take) pc_d = pc_q + br_off;
          end
          is_halt: state_d = S_HALT;
          default: ill_d = 1'b1;
        endcase
      end
      S_EXEC: begin
        nzp_d   = {alu_out[15],
                   alu_out == 16'h0000,
                   !alu_out[15] && (alu_out != 16'h0000)};
        state_d = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
    endcase
  end

  // FSM state, PC, instruction and registered control outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= 16'h0000;
      nzp_q   <= 3'b010;
      ill_q   <= 1'b0;
      alu_q   <= ALU_PASS;
      ir5_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      nzp_q   <= nzp_d;
      ill_q   <= ill_d;
      alu_q   <= alu_d;
      ir5_q   <= ir5_d;
      we_q    <= we_d;
    end
  end

  // Request drops with reset directly so an in-flight fetch is abandoned
  assign mem_req  = (state_q == S_FETCH) && !reset;
  assign mem_addr = pc_q;
  assign sr1      = instr_q[8:6];
  assign sr2      = instr_q[2:0];
  assign dr       = instr_q[11:9];
  assign IR       = instr_q[4:0];
  assign IR_5     = ir5_q;
  assign ALUctrl  = alu_q;
  assign reg_we   = we_q;
  assign nzp      = nzp_q;
  assign halted   = (state_q == S_HALT);
  assign illegal  = ill_q;

`ifdef LC3_SEQ_PERF_CNT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        retire;

  // Count retired instructions: ALU exec, any BR decode, HALT entry
  always_comb begin
    retire = (state_q == S_EXEC) ||
             ((state_q == S_DECODE) && (is_br || is_halt));
    cnt_d  = cnt_q + {15'd0, retire};
  end

  // Retire counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= 16'h0000;
    else       cnt_q <= cnt_d;
  end

  assign retired_cnt = cnt_q;
`endif

endmodule
